// File: rtl/tx_frame_sequencer.sv
// Serial frame sequencer for the TX emulation model: preamble, sync word, then PRBS7 or user payload.
// Optional payload bit-error injection is enabled by defining TX_ERR_INJECT_EN.
module tx_frame_sequencer #(
  parameter int unsigned       PRE_LEN   = 32,
  parameter int unsigned       SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hF0C3,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             src_sel_i,
  input  logic [6:0]       prbs_seed_i,
  input  logic [CNT_W-1:0] payload_len_i,
  input  logic             user_data_i,
  input  logic             user_valid_i,
`ifdef TX_ERR_INJECT_EN
  input  logic             err_inj_i,
  input  logic [CNT_W-1:0] err_pos_i,
`endif
  output logic             user_ready_o,
  output logic             data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  localparam int unsigned PhMax = (PRE_LEN > SYNC_W) ? PRE_LEN : SYNC_W;
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSync,
    StPayload,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             src_sel_q, src_sel_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             user_ready;
  logic             prbs_bit;
  logic             pay_bit;
  logic             inj_hit;
  logic [SYNC_W-1:0] sync_sh;

`ifdef TX_ERR_INJECT_EN
  logic             err_en_q, err_en_d;
  logic [CNT_W-1:0] err_pos_q, err_pos_d;
  logic [CNT_W-1:0] len_q, len_d;
`endif

  assign prbs_bit = lfsr_q[6] ^ lfsr_q[5];
  assign sync_sh  = SYNC_WORD << ph_cnt_q;

  // Payload index counts up from 0 as the down-counter drains from the latched length.
`ifdef TX_ERR_INJECT_EN
  assign inj_hit = err_en_q && ((len_q - pay_cnt_q) == err_pos_q);
`else
  assign inj_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    src_sel_d  = src_sel_q;
    lfsr_d     = lfsr_q;
    underrun_d = underrun_q;
    data_d     = 1'b0;
    busy_d     = (state_q != StIdle);
    done_d     = (state_q == StDone);
    user_ready = 1'b0;
    pay_bit    = 1'b0;
`ifdef TX_ERR_INJECT_EN
    err_en_d   = err_en_q;
    err_pos_d  = err_pos_q;
    len_d      = len_q;
`endif

    unique case (state_q)
      StIdle: begin
        // busy_q still covers the DONE output cycle, so a start there is dropped.
        if (start_i && !busy_q) begin
          state_d    = StPre;
          ph_cnt_d   = '0;
          pay_cnt_d  = payload_len_i;
          src_sel_d  = src_sel_i;
          lfsr_d     = (prbs_seed_i == 7'd0) ? 7'h7F : prbs_seed_i;
          underrun_d = 1'b0;
`ifdef TX_ERR_INJECT_EN
          err_en_d   = err_inj_i;
          err_pos_d  = err_pos_i;
          len_d      = payload_len_i;
`endif
        end
      end

      StPre: begin
        data_d = ~ph_cnt_q[0];
        if (ph_cnt_q == PhW'(PRE_LEN - 1)) begin
          ph_cnt_d = '0;
          state_d  = StSync;
        end else begin
          ph_cnt_d = ph_cnt_q + PhW'(1);
        end
      end

      StSync: begin
        data_d = sync_sh[SYNC_W-1];
        if (ph_cnt_q == PhW'(SYNC_W - 1)) begin
          ph_cnt_d = '0;
          state_d  = (pay_cnt_q == '0) ? StDone : StPayload;
        end else begin
          ph_cnt_d = ph_cnt_q + PhW'(1);
        end
      end

      StPayload: begin
        if (src_sel_q) begin
          user_ready = 1'b1;
          pay_bit    = user_valid_i & user_data_i;
          if (!user_valid_i) begin
            underrun_d = 1'b1;
          end
        end else begin
          pay_bit = prbs_bit;
          lfsr_d  = {lfsr_q[5:0], prbs_bit};
        end
        data_d    = pay_bit ^ inj_hit;
        pay_cnt_d = pay_cnt_q - CNT_W'(1);
        if (pay_cnt_q <= CNT_W'(1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ph_cnt_q   <= '0;
      pay_cnt_q  <= '0;
      src_sel_q  <= 1'b0;
      lfsr_q     <= 7'h7F;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef TX_ERR_INJECT_EN
      err_en_q   <= 1'b0;
      err_pos_q  <= '0;
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      src_sel_q  <= src_sel_d;
      lfsr_q     <= lfsr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef TX_ERR_INJECT_EN
      err_en_q   <= err_en_d;
      err_pos_q  <= err_pos_d;
      len_q      <= len_d;
`endif
    end
  end

  assign user_ready_o = user_ready;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;

endmodule
